// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signals of the UART tx arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    import uart_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_din;
    logic                      tx_wr_en;
    logic                      tx_busy;
    logic [IDX_W-1:0]          grant_id;
    logic                      locked;

    modport master (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_din, tx_wr_en, grant_id, locked
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_din, tx_wr_en, grant_id, locked
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - rotate-priority selector starting after the pointer
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] sel_onehot,
    output logic [IDX_W-1:0]   sel_idx,
    output logic               sel_valid
);

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   idx;

    assign eligible = req & mask;

    // Walk ptr+1, ptr+2, ... wrapping; the pointer itself is visited last.
    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        sel_valid  = 1'b0;
        idx        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!sel_valid && eligible[idx]) begin
                sel_valid       = 1'b1;
                sel_idx         = idx;
                sel_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART byte transmitter
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDX_W     = 2,
    parameter int LOCK_EN   = 1,
    parameter int MAX_BURST = 16
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    uart_tx_arbiter_if.master bus
);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gid_r;
    logic               locked_r;
    logic [7:0]         burst_cnt;
    logic [7:0]         burst_inc;
    logic [DATA_W-1:0]  din_r;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] sel_oh;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic               accept;
    logic               release_lock;

    // A locked grant narrows eligibility to the current owner only.
    always_comb begin
        mask = '1;
        if (locked_r) begin
            mask        = '0;
            mask[gid_r] = 1'b1;
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (bus.req_valid),
        .ptr        (ptr),
        .mask       (mask),
        .sel_onehot (sel_oh),
        .sel_idx    (sel_idx),
        .sel_valid  (sel_valid)
    );

    assign burst_inc    = burst_cnt + 8'd1;
    assign release_lock = bus.req_last[sel_idx] || (burst_inc >= 8'(MAX_BURST));

    assign bus.tx_din   = din_r;
    assign bus.grant_id = gid_r;
    assign bus.locked   = locked_r;

    // Next state and handshake outputs; accept only from IDLE with an idle transmitter.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.req_ready = '0;
        bus.tx_wr_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_valid && !bus.tx_busy) begin
                    accept        = 1'b1;
                    bus.req_ready = sel_oh;
                    state_nxt     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.tx_wr_en = 1'b1;
                state_nxt    = ST_WAIT_BUSY;
            end
            // tx_busy lags wr_en by one cycle; a low value here is stale.
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register plus byte, grant, pointer and lock bookkeeping on accept.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= IDX_W'(NUM_REQ - 1);
            gid_r     <= '0;
            locked_r  <= 1'b0;
            burst_cnt <= 8'd0;
            din_r     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                din_r <= bus.req_data[int'(sel_idx)*DATA_W +: DATA_W];
                gid_r <= sel_idx;
                ptr   <= sel_idx;
                if (LOCK_EN != 0) begin
                    if (release_lock) begin
                        locked_r  <= 1'b0;
                        burst_cnt <= 8'd0;
                    end else begin
                        locked_r  <= 1'b1;
                        burst_cnt <= burst_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed checks of uart_tx_arbiter with and without packet locking
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int FRAME  = 6;
    localparam int BUDGET = 400;

    typedef struct {
        logic [7:0] din;
        logic [1:0] gid;
        logic       lck;
    } ev_t;

    typedef struct {
        int         scen;
        int         req;
        logic [7:0] data;
        logic       last;
    } load_t;

    typedef struct {
        int         scen;
        logic [7:0] din;
        logic [1:0] gid;
        logic       lck;
    } exp_t;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;
    always #10 clk_50m = ~clk_50m;

    uart_tx_arbiter_if #(.NUM_REQ(4), .IDX_W(2)) bus0 ();
    uart_tx_arbiter_if #(.NUM_REQ(4), .IDX_W(2)) bus1 ();

    uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .LOCK_EN(0), .MAX_BURST(16)) dut0 (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus0)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .LOCK_EN(1), .MAX_BURST(4)) dut1 (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus1)
    );

    logic [8:0]  q [2][4][$];
    logic [3:0]  vld [2];
    logic [3:0]  lst [2];
    logic [31:0] dat [2];
    logic        busy [2];
    int          busy_cnt [2];
    logic [3:0]  rdy_s [2];
    logic        wr_s [2];
    logic [7:0]  din_s [2];
    logic [1:0]  gid_s [2];
    logic        lck_s [2];
    ev_t         log_q [2][$];
    int          outstanding [2];
    int          seen_hi [2];
    int          proto_err;
    int          total;
    int          bad;
    load_t       loads [$];
    exp_t        exps [$];

    assign bus0.req_valid = vld[0];
    assign bus0.req_data  = dat[0];
    assign bus0.req_last  = lst[0];
    assign bus0.tx_busy   = busy[0];
    assign bus1.req_valid = vld[1];
    assign bus1.req_data  = dat[1];
    assign bus1.req_last  = lst[1];
    assign bus1.tx_busy   = busy[1];

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic refresh();
        logic [8:0] e;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                e = (q[d][i].size() != 0) ? q[d][i][0] : 9'h000;
                vld[d][i]         = (q[d][i].size() != 0);
                lst[d][i]         = e[8];
                dat[d][8*i +: 8]  = e[7:0];
            end
        end
    endtask

    task automatic tick();
        ev_t ev;
        @(negedge clk_50m);
        rdy_s[0] = bus0.req_ready; wr_s[0] = bus0.tx_wr_en; din_s[0] = bus0.tx_din;
        gid_s[0] = bus0.grant_id;  lck_s[0] = bus0.locked;
        rdy_s[1] = bus1.req_ready; wr_s[1] = bus1.tx_wr_en; din_s[1] = bus1.tx_din;
        gid_s[1] = bus1.grant_id;  lck_s[1] = bus1.locked;
        for (int d = 0; d < 2; d++) begin
            if ((rdy_s[d] & ~vld[d]) != 4'b0000) proto_err++;
            if ($countones(rdy_s[d]) > 1) proto_err++;
            if (wr_s[d]) begin
                if (outstanding[d] != 0) proto_err++;
                outstanding[d] = 1;
                seen_hi[d]     = 0;
                ev.din = din_s[d]; ev.gid = gid_s[d]; ev.lck = lck_s[d];
                log_q[d].push_back(ev);
            end else if (busy[d]) begin
                seen_hi[d] = 1;
            end else if (seen_hi[d] != 0) begin
                outstanding[d] = 0;
            end
        end
        @(posedge clk_50m);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (rdy_s[d][i] && vld[d][i]) void'(q[d][i].pop_front());
            end
            // Transmitter model: busy rises the cycle after wr_en and lasts FRAME cycles.
            if (wr_s[d]) busy_cnt[d] = FRAME;
            else if (busy_cnt[d] > 0) busy_cnt[d]--;
            busy[d] = (busy_cnt[d] != 0);
        end
        refresh();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) q[d][i].delete();
            busy_cnt[d] = 0; busy[d] = 1'b0;
        end
        refresh();
        tick();
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            log_q[d].delete(); outstanding[d] = 0; seen_hi[d] = 0;
        end
    endtask

    task automatic wait_log(input int d, input int n, input string nm);
        int c;
        c = 0;
        while (log_q[d].size() < n && c < BUDGET) begin
            tick();
            c++;
        end
        if (log_q[d].size() < n) chk({nm, "_timeout"}, log_q[d].size(), n);
    endtask

    task automatic run_scen(input int s, input int d);
        int n;
        int k;
        ev_t e;
        n = 0;
        for (int j = 0; j < loads.size(); j++) begin
            if (loads[j].scen == s) q[d][loads[j].req].push_back({loads[j].last, loads[j].data});
        end
        for (int j = 0; j < exps.size(); j++) if (exps[j].scen == s) n++;
        refresh();
        wait_log(d, n, $sformatf("s%0d", s));
        for (int j = 0; j < FRAME + 4; j++) tick();
        chk($sformatf("s%0d_count", s), log_q[d].size(), n);
        k = 0;
        for (int j = 0; j < exps.size(); j++) begin
            if (exps[j].scen == s) begin
                if (k < log_q[d].size()) begin
                    e = log_q[d][k];
                    chk($sformatf("s%0d_b%0d_din", s, k), int'(e.din), int'(exps[j].din));
                    chk($sformatf("s%0d_b%0d_gid", s, k), int'(e.gid), int'(exps[j].gid));
                    chk($sformatf("s%0d_b%0d_lck", s, k), int'(e.lck), int'(exps[j].lck));
                end
                k++;
            end
        end
    endtask

    initial begin
        int c;
        int early;
        int base;
        total = 0; bad = 0; proto_err = 0;

        // Scenario 2: dut0, no locking, strict rotation 0,1,2,3,0.
        loads.push_back('{2, 0, 8'h10, 1'b0});
        loads.push_back('{2, 0, 8'h10, 1'b0});
        loads.push_back('{2, 1, 8'h11, 1'b0});
        loads.push_back('{2, 2, 8'h12, 1'b0});
        loads.push_back('{2, 3, 8'h13, 1'b0});
        exps.push_back('{2, 8'h10, 2'd0, 1'b0});
        exps.push_back('{2, 8'h11, 2'd1, 1'b0});
        exps.push_back('{2, 8'h12, 2'd2, 1'b0});
        exps.push_back('{2, 8'h13, 2'd3, 1'b0});
        exps.push_back('{2, 8'h10, 2'd0, 1'b0});
        // Scenario 3: dut1, req1 three-byte packet holds the grant against req0/req2.
        loads.push_back('{3, 0, 8'h30, 1'b1});
        loads.push_back('{3, 0, 8'h31, 1'b1});
        loads.push_back('{3, 1, 8'h21, 1'b0});
        loads.push_back('{3, 1, 8'h22, 1'b0});
        loads.push_back('{3, 1, 8'h23, 1'b1});
        loads.push_back('{3, 2, 8'h32, 1'b1});
        exps.push_back('{3, 8'h30, 2'd0, 1'b0});
        exps.push_back('{3, 8'h21, 2'd1, 1'b1});
        exps.push_back('{3, 8'h22, 2'd1, 1'b1});
        exps.push_back('{3, 8'h23, 2'd1, 1'b0});
        exps.push_back('{3, 8'h32, 2'd2, 1'b0});
        exps.push_back('{3, 8'h31, 2'd0, 1'b0});
        // Scenario 4: dut1, req3 streams without last; burst limit 4 lets req0 in.
        loads.push_back('{4, 0, 8'h50, 1'b1});
        loads.push_back('{4, 0, 8'h51, 1'b1});
        for (int i = 0; i < 10; i++) loads.push_back('{4, 3, 8'(8'h40 + i), 1'b0});
        exps.push_back('{4, 8'h50, 2'd0, 1'b0});
        exps.push_back('{4, 8'h40, 2'd3, 1'b1});
        exps.push_back('{4, 8'h41, 2'd3, 1'b1});
        exps.push_back('{4, 8'h42, 2'd3, 1'b1});
        exps.push_back('{4, 8'h43, 2'd3, 1'b0});
        exps.push_back('{4, 8'h51, 2'd0, 1'b0});
        exps.push_back('{4, 8'h44, 2'd3, 1'b1});
        exps.push_back('{4, 8'h45, 2'd3, 1'b1});
        exps.push_back('{4, 8'h46, 2'd3, 1'b1});
        exps.push_back('{4, 8'h47, 2'd3, 1'b0});
        exps.push_back('{4, 8'h48, 2'd3, 1'b1});
        exps.push_back('{4, 8'h49, 2'd3, 1'b1});

        for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0; busy_cnt[d] = 0; outstanding[d] = 0; seen_hi[d] = 0;
        end
        refresh();
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_ready", d), int'(rdy_s[d]), 0);
            chk($sformatf("rst%0d_wr", d), int'(wr_s[d]), 0);
            chk($sformatf("rst%0d_din", d), int'(din_s[d]), 0);
            chk($sformatf("rst%0d_gid", d), int'(gid_s[d]), 0);
            chk($sformatf("rst%0d_lck", d), int'(lck_s[d]), 0);
        end

        // Scenario 1: single byte, one-cycle issue latency, pacing on busy.
        do_reset();
        q[0][0].push_back({1'b1, 8'hA5});
        refresh();
        c = 0;
        do begin tick(); c++; end while (rdy_s[0] == 4'b0000 && c < 10);
        chk("s1_ready", int'(rdy_s[0]), 1);
        q[0][0].push_back({1'b1, 8'h5A});
        refresh();
        tick();
        chk("s1_wr", int'(wr_s[0]), 1);
        chk("s1_din", int'(din_s[0]), 8'hA5);
        // Accept at t, wr at t+1, busy t+2..t+1+FRAME, seen low at t+2+FRAME, next accept t+3+FRAME.
        c = 0; early = 0;
        do begin tick(); c++; if (wr_s[0]) early++; end while (rdy_s[0] == 4'b0000 && c < 40);
        chk("s1_gap", c, FRAME + 2);
        chk("s1_extra_wr", early, 0);
        wait_log(0, 2, "s1");
        if (log_q[0].size() >= 2) chk("s1_din2", int'(log_q[0][1].din), 8'h5A);

        do_reset();
        run_scen(2, 0);
        do_reset();
        run_scen(3, 1);
        do_reset();
        run_scen(4, 1);

        // Scenario 5: locked owner (req3) has no data; req0 must not be served.
        chk("s5_locked", int'(lck_s[1]), 1);
        chk("s5_owner", int'(gid_s[1]), 3);
        q[1][0].push_back({1'b1, 8'h60});
        refresh();
        c = 0; early = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            if (rdy_s[1] != 4'b0000) c++;
            if (wr_s[1]) early++;
        end
        chk("s5_no_ready", c, 0);
        chk("s5_no_wr", early, 0);
        base = log_q[1].size();
        q[1][3].push_back({1'b1, 8'h4A});
        refresh();
        wait_log(1, base + 2, "s5");
        if (log_q[1].size() >= base + 2) begin
            chk("s5_resume_din", int'(log_q[1][base].din), 8'h4A);
            chk("s5_resume_gid", int'(log_q[1][base].gid), 3);
            chk("s5_after_din", int'(log_q[1][base + 1].din), 8'h60);
            chk("s5_after_gid", int'(log_q[1][base + 1].gid), 0);
        end
        for (int j = 0; j < FRAME + 4; j++) tick();

        // Scenario 6: reset during WAIT_DONE while the transmitter is still busy.
        do_reset();
        q[1][1].push_back({1'b1, 8'h71});
        refresh();
        wait_log(1, 1, "s6");
        tick();
        tick();
        q[1][2].push_back({1'b1, 8'h70});
        q[1][0].push_back({1'b1, 8'h72});
        refresh();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("s6_rst_ready", int'(rdy_s[1]), 0);
        chk("s6_rst_wr", int'(wr_s[1]), 0);
        chk("s6_rst_din", int'(din_s[1]), 0);
        chk("s6_rst_gid", int'(gid_s[1]), 0);
        chk("s6_rst_lck", int'(lck_s[1]), 0);
        c = 0; early = 0;
        while (rdy_s[1] == 4'b0000 && c < 40) begin
            tick();
            c++;
            if (busy[1] && rdy_s[1] != 4'b0000) early++;
        end
        chk("s6_wait_busy", early, 0);
        chk("s6_first_ready", int'(rdy_s[1]), 1);
        wait_log(1, 3, "s6b");
        if (log_q[1].size() >= 3) begin
            chk("s6_b1_din", int'(log_q[1][1].din), 8'h72);
            chk("s6_b2_din", int'(log_q[1][2].din), 8'h70);
            chk("s6_b2_gid", int'(log_q[1][2].gid), 2);
        end
        for (int j = 0; j < FRAME + 4; j++) tick();

        chk("protocol", proto_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
